// File: rtl/au_div_responder.sv
// WAIT-handshake divider: latches signed Q-format operands on a launch, runs a
// restoring divide one quotient bit per cycle, then pulses continue_o for one cycle.
module au_div_responder #(
    parameter int W    = 16,
    parameter int FRAC = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         run_i,
    input  logic [1:0]   ctl_c,
    input  logic [W-1:0] num_i,
    input  logic [W-1:0] den_i,
    output logic         continue_o,
    output logic         busy_o,
    output logic [W-1:0] q_o,
    output logic         dz_o
);
    localparam int N  = W + FRAC;
    localparam int CW = $clog2(N + 1);

    localparam logic [W-1:0] MAX_POS = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] MIN_NEG = {1'b1, {(W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [W-1:0]  rem;
    logic [W-1:0]  dmag;
    logic [N-1:0]  dvd;
    logic [N-1:0]  quo;
    logic          sign;

    logic [W-1:0]  nabs, dabs;
    logic [W:0]    rem_sh, rem_sub;
    logic          fits;
    logic [W-1:0]  rem_nx;
    logic [N-1:0]  quo_nx;
    logic          pos_ovf, neg_ovf;
    logic [W-1:0]  q_fin;

    // Magnitudes as W-bit unsigned: 2^(W-1) from the most-negative input fits.
    assign nabs = num_i[W-1] ? (~num_i + 1'b1) : num_i;
    assign dabs = den_i[W-1] ? (~den_i + 1'b1) : den_i;

    // The borrow out of the W+1-bit trial subtraction decides the quotient bit.
    assign rem_sh  = {rem, dvd[N-1]};
    assign rem_sub = rem_sh - {1'b0, dmag};
    assign fits    = ~rem_sub[W];
    assign rem_nx  = fits ? rem_sub[W-1:0] : rem_sh[W-1:0];
    assign quo_nx  = {quo[N-2:0], fits};

    assign pos_ovf = quo_nx > {{(N-W){1'b0}}, MAX_POS};
    assign neg_ovf = quo_nx > {{(N-W){1'b0}}, MIN_NEG};
    assign q_fin   = sign ? (neg_ovf ? MIN_NEG : (~quo_nx[W-1:0] + 1'b1))
                          : (pos_ovf ? MAX_POS : quo_nx[W-1:0]);

    assign continue_o = (state == DONE);
    assign busy_o     = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            rem   <= '0;
            dmag  <= '0;
            dvd   <= '0;
            quo   <= '0;
            sign  <= 1'b0;
            q_o   <= '0;
            dz_o  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (run_i && ctl_c == 2'b01) begin
                        sign <= num_i[W-1] ^ den_i[W-1];
                        dvd  <= {nabs, {FRAC{1'b0}}};
                        dmag <= dabs;
                        rem  <= '0;
                        quo  <= '0;
                        cnt  <= CW'(N);
                        dz_o <= 1'b0;
                        if (den_i == '0) begin
                            dz_o  <= 1'b1;
                            q_o   <= num_i[W-1] ? MIN_NEG : MAX_POS;
                            state <= DONE;
                        end else begin
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    rem <= rem_nx;
                    quo <= quo_nx;
                    dvd <= {dvd[N-2:0], 1'b0};
                    cnt <= cnt - 1'b1;
                    if (cnt == CW'(1)) begin
                        q_o   <= q_fin;
                        state <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/au_div_responder.md
Name: au_div_responder

Overview:
- Arithmetic-unit responder on the sequencer's WAIT handshake.
- When the running sequencer presents a WAIT instruction (ctl_c = 01), the block latches two signed fixed-point operands and runs a one-bit-per-cycle restoring division.
- When the quotient is ready it pulses continue_o, which the sequencer samples to advance its PC.
- Sits beside the 1-cycle ADD/SUB/MUL datapath and supplies the sequencer's continue_i.

Parameters:
- W, 16, operand/result width (signed two's complement)
- FRAC, 8, fractional bits (Q(W-FRAC).FRAC format); divider iterations N = W+FRAC

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- run_i  in  1  sequencer running (inverse of sequencer ready)
- ctl_c  in  2  sequencer flow field; 01 = WAIT/launch
- num_i  in  W  dividend, signed Q format
- den_i  in  W  divisor, signed Q format
- continue_o  out  1  one-cycle done pulse, to sequencer continue_i
- busy_o  out  1  high in CALC or DONE
- q_o  out  W  quotient, held until next launch
- dz_o  out  1  divide-by-zero flag for last operation, held until next launch

Behaviour:
- Reset (async, rst=1): state=IDLE; continue_o=0, busy_o=0, q_o=0, dz_o=0; internal counter, remainder and operand registers = 0.
- States: IDLE, CALC, DONE.
- IDLE -> launch when run_i=1 and ctl_c=01 at a rising edge. On that edge:
  - latch |num_i|, |den_i| and sign = num_i[W-1] XOR den_i[W-1]
  - clear dz_o; load iteration counter = N
  - if den_i=0: set dz_o=1 and go to DONE; otherwise go to CALC.
- IDLE with any other ctl_c, or with run_i=0: no action; outputs hold.
- CALC: restoring division of (|num| << FRAC) by |den|, one quotient bit per cycle, MSB first.
  - Remainder width W+1; partial quotient width N.
  - Counter decrements each cycle; after N CALC cycles go to DONE.
- DONE: lasts exactly one cycle; continue_o=1 combinationally from state. Next edge -> IDLE, unconditionally.
- q_o is registered on the CALC->DONE (or IDLE->DONE) edge, so it is valid in the same cycle continue_o is high.
- Latency: launch edge at cycle 0; continue_o high during cycle N+1 (cycle 25 at defaults). Divide-by-zero: continue_o high during cycle 1.
- Result rules:
  - Truncate toward zero; apply sign after magnitude division.
  - Positive magnitude > 2^(W-1)-1 saturates to 0x7FFF.
  - Negative magnitude > 2^(W-1) saturates to 0x8000.
  - Zero result is always +0 (never negated).
- Divide-by-zero: q_o = 0x7FFF if num_i >= 0, else 0x8000; dz_o=1.
- Back-to-back WAITs: the sequencer advances its PC on the same edge the block leaves DONE. In the following IDLE cycle a new ctl_c=01 launches normally. The same instruction is never double-launched, because DONE always returns to IDLE.
- ctl_c, run_i, num_i or den_i changing during CALC/DONE: ignored; the operation completes with latched operands.
- run_i falling mid-operation: ignored; continue_o still pulses once.
- Reset mid-CALC or mid-DONE: immediate return to IDLE, no continue_o pulse, q_o=0.
- Most-negative operand (0x8000): magnitude 2^(W-1) is representable in the W+1-bit internal width.

Test Plan:
- Basic divide: run_i=1, ctl_c=01, num=0x0300 (3.0), den=0x0200 (2.0) -> continue_o high for exactly one cycle at cycle 25, q_o=0x0180, dz_o=0, busy_o low from cycle 26.
- Signed divide: num=0xFD00 (-3.0), den=0x0200 -> q_o=0xFE80 (-1.5). Then num=0xFD00, den=0xFE00 -> q_o=0x0180.
- Divide by zero: num=0x0100, den=0x0000 -> continue_o at cycle 1, q_o=0x7FFF, dz_o=1. Repeat with num=0xFF00 -> q_o=0x8000.
- Saturation: num=0x7F00, den=0x0001 -> q_o=0x7FFF. num=0x8000, den=0x0001 -> q_o=0x8000.
- Back-to-back: ctl_c=01 held through the first DONE, then re-presented in the IDLE cycle with new operands 0x0100/0x0400 -> two distinct continue_o pulses 26 cycles apart; second q_o=0x0040. With ctl_c=00 in the gap, no second launch.
- Reset mid-op: assert rst at cycle 10 of CALC -> no continue_o pulse, q_o=0, state IDLE. A launch after reset release completes normally.
